// File: rtl/circular_buffer_pkg.sv
// circular_buffer_pkg: shared types and constants for the circular trace buffer and its reader
package circular_buffer_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int N_DEFAULT = 6;
endpackage

// File: rtl/cb_word_serializer.sv
// cb_word_serializer: splits a loaded 32-bit word into a valid/ready byte stream, LSB first
module cb_word_serializer
  import circular_buffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  logic [31:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic fire;
  assign fire = valid_q & ready_i;
  assign last_o = cnt_q == CNT_W'(BYTES_PER_WORD - 1);
  assign valid_o = valid_q;
  assign byte_o = word_q[{cnt_q, 3'b000} +: 8];
  always_comb begin
    word_d = load_i ? word_i : word_q;
    cnt_d = load_i ? '0 : fire ? cnt_q + 1'b1 : cnt_q;
    valid_d = load_i ? 1'b1 : (fire && last_o) ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/circular_buffer_reader.sv
// circular_buffer_reader: walks a range of trace buffer entries and streams them out as bytes
module circular_buffer_reader
  import circular_buffer_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int IDX_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N-1:0]     first_idx_i,
  input  logic [N:0]       num_words_i,
  output logic [IDX_W-1:0] read_index_o,
  input  logic [31:0]      read_data_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             busy_o,
  output logic             done_o
);
  localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};
  state_e state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N:0] rem_q, rem_d;
  logic last, word_sent;
  cb_word_serializer u_ser (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q == CAPTURE),
    .word_i (read_data_i),
    .ready_i(byte_ready_i),
    .byte_o (byte_o),
    .valid_o(byte_valid_o),
    .last_o (last)
  );
  assign word_sent = byte_valid_o & byte_ready_i & last;
  assign read_index_o = {{(IDX_W - N){1'b0}}, idx_q};
  assign busy_o = state_q inside {ISSUE, CAPTURE, SEND};
  assign done_o = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (start_i) begin
        idx_d = first_idx_i;
        rem_d = num_words_i == '0 ? DEPTH : num_words_i;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND: if (word_sent) begin
        rem_d = rem_q - 1'b1;
        idx_d = idx_q + 1'b1;
        state_d = rem_q == (N+1)'(1) ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_circular_buffer_reader.sv
// tb_circular_buffer_reader: directed and randomized dumps checked against a byte-queue model
module tb_circular_buffer_reader;
  logic clk = 0;
  logic rst_ni = 0;
  logic start_i = 0;
  logic [5:0] first_idx_i = 0;
  logic [6:0] num_words_i = 0;
  logic [19:0] read_index_o;
  logic [31:0] read_data_i;
  logic [7:0] byte_o;
  logic byte_valid_o;
  logic byte_ready_i = 0;
  logic busy_o, done_o;
  logic [31:0] mem [64];
  logic [7:0] exp_q [$];
  int total = 0, bad = 0, nbytes = 0, dones = 0;

  always #5 clk = ~clk;
  assign read_data_i = mem[read_index_o[5:0]];

  circular_buffer_reader dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .first_idx_i(first_idx_i),
    .num_words_i(num_words_i), .read_index_o(read_index_o), .read_data_i(read_data_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  task automatic build_exp(input int first, input int num);
    int n;
    logic [31:0] e;
    n = num == 0 ? 64 : num;
    exp_q.delete();
    for (int w = 0; w < n; w++) begin
      e = mem[(first + w) % 64];
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((e >> (8 * k)) & 32'hff));
    end
  endtask

  task automatic start_dump(input int first, input int num);
    first_idx_i = 6'(first);
    num_words_i = 7'(num);
    start_i = 1;
    step();
    start_i = 0;
    chk("issue_busy", busy_o, 1);
    chk("issue_idx", read_index_o, first);
    chk("issue_valid", byte_valid_o, 0);
    step();
    chk("capture_idx", read_index_o, first);
    chk("capture_valid", byte_valid_o, 0);
    step();
    chk("lat_valid", byte_valid_o, 1);
  endtask

  task automatic drain(input int first, input int rmode, input bit ign, input int abort_byte);
    int stall = 7;
    bit pv = 0, pr = 0, seen = 0, fin = 0;
    logic [7:0] pb = 0;
    nbytes = 0;
    dones = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (abort_byte >= 0 && nbytes == abort_byte && byte_valid_o) begin
        #2 rst_ni = 0;
        #1;
        chk("rst_valid", byte_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_byte", byte_o, 0);
        exp_q.delete();
        byte_ready_i = 0;
        step();
        step();
        rst_ni = 1;
        for (int i = 0; i < 3; i++) begin
          step();
          chk("rst_idle", {busy_o, done_o, byte_valid_o}, 0);
        end
        return;
      end
      if (pv && !pr) begin
        chk("hold_valid", byte_valid_o, 1);
        chk("hold_byte", byte_o, pb);
      end
      if (done_o) begin
        dones++;
        seen = 1;
        chk("done_busy", busy_o, 0);
        chk("done_all", exp_q.size(), 0);
      end else if (seen) begin
        chk("one_done", dones, 1);
        chk("idle_busy", busy_o, 0);
        fin = 1;
      end
      if (busy_o && !byte_valid_o) chk("ridx", read_index_o, (first + nbytes / 4) % 64);
      if (rmode == 0) byte_ready_i = 1;
      else if (rmode == 1) byte_ready_i = 1'($urandom_range(0, 1));
      else if (byte_valid_o && nbytes == 1 && stall > 0) begin
        byte_ready_i = 0;
        stall--;
      end else byte_ready_i = 1;
      if (ign && cyc == 5) begin
        start_i = 1;
        first_idx_i = 6'(first + 17);
      end else start_i = 0;
      if (rmode == 1 && byte_valid_o && nbytes % 4 == 1) mem[read_index_o[5:0]] = $urandom;
      if (byte_valid_o && byte_ready_i) begin
        chk("byte_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("byte", byte_o, exp_q.pop_front());
        nbytes++;
      end
      pv = byte_valid_o;
      pr = byte_ready_i;
      pb = byte_o;
      step();
    end
    chk("timeout", fin, 1);
  endtask

  initial begin
    int f, n;
    preload();
    #12;
    chk("reset_out", {read_index_o, byte_o, byte_valid_o, busy_o, done_o}, 0);
    rst_ni = 1;
    step();
    chk("idle_after_reset", {busy_o, byte_valid_o, done_o}, 0);

    build_exp(62, 3);
    start_dump(62, 3);
    drain(62, 0, 0, -1);
    chk("wrap_bytes", nbytes, 12);

    build_exp(5, 0);
    start_dump(5, 0);
    drain(5, 0, 0, -1);
    chk("zero_bytes", nbytes, 256);

    mem[20] = 32'h8000_00AB;
    build_exp(20, 1);
    start_dump(20, 1);
    drain(20, 2, 0, -1);
    chk("bp_bytes", nbytes, 4);

    preload();
    build_exp(30, 3);
    start_dump(30, 3);
    drain(30, 1, 1, -1);
    chk("ign_bytes", nbytes, 12);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ign_no_restart", {busy_o, done_o}, 0);
    end

    preload();
    build_exp(40, 4);
    start_dump(40, 4);
    drain(40, 0, 0, 8);
    build_exp(0, 1);
    start_dump(0, 1);
    drain(0, 0, 0, -1);
    chk("post_rst_bytes", nbytes, 4);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      f = $urandom_range(0, 63);
      n = r == 5 ? 0 : $urandom_range(1, 9);
      build_exp(f, n);
      start_dump(f, n);
      drain(f, 1, 0, -1);
      chk("rand_bytes", nbytes, (n == 0 ? 64 : n) * 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circular_buffer_reader.md
Name: circular_buffer_reader

Overview:
- Drain-side companion to the circular trace buffer.
- On a start pulse it walks a range of buffer entries through the buffer's index/data read port, one word at a time.
- It serialises each 32-bit entry into four bytes on a valid/ready byte stream, which feeds the UART TX path for host dump.
- It only reads; write pointer and lookup logic remain in the buffer.

Parameters:
- N, 6, log2 of buffer depth; DEPTH = 2**N entries.
- IDX_W, 20, width of the buffer read-index port; bits above N are driven 0.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle dump request; sampled only in IDLE
- first_idx_i  input  N  first entry index, latched on accepted start
- num_words_i  input  N+1  entries to dump, latched on start; 0 means DEPTH
- read_index_o  output  IDX_W  index presented to buffer read port
- read_data_i  input  32  buffer read data for read_index_o
- byte_o  output  8  stream data
- byte_valid_o  output  1  stream valid
- byte_ready_i  input  1  stream ready (sink)
- busy_o  output  1  high from accepted start until done
- done_o  output  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset is asynchronous and may be asserted at any point, including mid-dump. The in-flight dump is abandoned and no done_o pulse is produced. After release, the FSM waits for a new start_i.
- FSM states: IDLE, ISSUE, CAPTURE, SEND, DONE.
  - IDLE: busy_o = 0. If start_i = 1: latch idx <- first_idx_i, remaining <- (num_words_i == 0 ? DEPTH : num_words_i); go to ISSUE.
  - ISSUE: drive read_index_o = {zeros, idx}; go to CAPTURE. read_index_o holds this value through CAPTURE.
  - CAPTURE: register word <- read_data_i, set byte_cnt <- 0, go to SEND. The one-cycle index-to-sample gap supports both combinational and one-cycle-registered buffer reads.
  - SEND:
    - byte_valid_o = 1; byte_o = word[8*byte_cnt +: 8], least-significant byte first.
    - On byte_valid_o & byte_ready_i: byte_cnt++.
    - When byte 3 is accepted: remaining--, idx <- (idx + 1) mod DEPTH (wraps DEPTH-1 -> 0).
    - Then go to ISSUE if remaining after decrement is nonzero, otherwise to DONE.
  - DONE: done_o = 1 for exactly one cycle, busy_o = 0; go to IDLE.
- Handshake rules:
  - Once byte_valid_o is asserted, byte_o and byte_valid_o are held stable until accepted.
  - byte_valid_o is never dropped without a handshake.
  - byte_valid_o does not depend combinationally on byte_ready_i.
- byte_valid_o is 0 in every state except SEND.
- busy_o is 1 in ISSUE, CAPTURE and SEND.
- start_i outside IDLE (including in DONE) is ignored; it is not queued.
- Latency: from start_i to first byte_valid_o is 2 cycles (ISSUE, CAPTURE). With byte_ready_i held high, throughput is 4 bytes per 6 cycles.
- The word is captured once per entry. Buffer writes occurring after CAPTURE do not alter bytes already in flight.
- Widths: idx is N bits and wraps naturally. remaining is N+1 bits so that DEPTH is representable. No overflow is possible.

Decomposition:
- Package circular_buffer_pkg:
  - state enum type (IDLE, ISSUE, CAPTURE, SEND, DONE);
  - BYTES_PER_WORD = 4;
  - default N = 6.
  The buffer itself will later import the same package.
- One natural sub-module, cb_word_serializer: 32-bit word in, byte stream out, with a valid/ready handshake and a last-byte flag. The FSM in the top block handles index walking and counting only.

Test Plan:
- Full-range wrap: preload entry i = 0x1000_0000 + i; start with first_idx_i = 62, num_words_i = 3, byte_ready_i = 1. Expected:
  - read_index_o sequence is 62, 63, 0;
  - bytes are 3E 00 00 10, 3F 00 00 10, 00 00 00 10;
  - done_o pulses once;
  - busy_o falls in the DONE cycle.
- Zero count means DEPTH: num_words_i = 0, first_idx_i = 5. Expected: exactly 256 bytes; last word is entry 4 (04 00 00 10); done_o pulses once.
- Backpressure: byte_ready_i low for 7 cycles during byte 1 of word 0x8000_00AB. Expected: byte_o = 0x00 is held stable with valid high throughout; then order AB 00 00 80 is preserved with no duplicates.
- Ignored start: pulse start_i mid-dump with a different first_idx_i. Expected: current dump unaffected, no second dump starts, a single done_o.
- Async reset mid-SEND: drop rst_ni asynchronously during word 2. Expected:
  - byte_valid_o, busy_o and done_o go to 0 immediately, with no done_o pulse;
  - a subsequent start with first_idx_i = 0, num_words_i = 1 produces 4 correct bytes.
- Latency: start_i at cycle t. Expected: read_index_o valid at t+1, first byte_valid_o at t+3 (two cycles after ISSUE).
